// File: rtl/vga_timing_core.sv
// vga_timing_core: single-clock timing hub for the memory-game display.
// Produces a divide-by-2 pixel clock with matching pixel-enable tick, the
// VGA raster position with sync/data-enable/frame decodes, and a slow
// square wave used to pace cursor movement. Everything runs on clock_50M.
module vga_timing_core #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned SLOW_HZ  = 1,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clock_50M,
  input  logic       reset,
  output logic       clock_25M,
  output logic       pix_tick,
  output logic       clock_1Hz,
  output logic [9:0] sx,
  output logic [9:0] sy,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Slow counter is never narrower than 25 bits so the default 1 Hz
  // half-period (25_000_000 cycles) always fits.
  localparam int unsigned SLOW_HALF = CLK_HZ / (2 * SLOW_HZ);
  localparam int unsigned SLOW_W    = ($clog2(SLOW_HALF) > 25) ? $clog2(SLOW_HALF) : 25;
  localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_HALF - 1);

  logic [SLOW_W-1:0] slow_cnt;

  // Pixel clock: free-running toggle, starts low out of reset.
  always_ff @(posedge clock_50M) begin
    if (reset) clock_25M <= 1'b0;
    else       clock_25M <= ~clock_25M;
  end

  // Pixel enable: active on the edge that raises clock_25M.
  always_comb begin
    pix_tick = ~clock_25M;
  end

  // Raster position: advances once per pixel, wraps by compare at line/frame end.
  always_ff @(posedge clock_50M) begin
    if (reset) begin
      sx <= '0;
      sy <= '0;
    end else if (pix_tick) begin
      if (sx == H_LAST) begin
        sx <= '0;
        if (sy == V_LAST) sy <= '0;
        else              sy <= sy + 10'd1;
      end else begin
        sx <= sx + 10'd1;
      end
    end
  end

  // Slow square wave: half-period counter, output inverts on terminal count.
  always_ff @(posedge clock_50M) begin
    if (reset) begin
      slow_cnt  <= '0;
      clock_1Hz <= 1'b0;
    end else if (slow_cnt == SLOW_LAST) begin
      slow_cnt  <= '0;
      clock_1Hz <= ~clock_1Hz;
    end else begin
      slow_cnt  <= slow_cnt + SLOW_W'(1);
    end
  end

  // Raster decodes: sync pulses are active-low, frame marks start of vertical blanking.
  always_comb begin
    hsync = ~((sx >= HS_FIRST) && (sx <= HS_LAST));
    vsync = ~((sy >= VS_FIRST) && (sy <= VS_LAST));
    de    = (sx < H_ACT) && (sy < V_ACT);
    frame = (sy == V_ACT) && (sx == 10'd0);
  end

endmodule

// File: tb/tb_vga_timing_core.sv
// tb_vga_timing_core: directed checks of vga_timing_core with full-width
// horizontal timing, a shortened vertical frame (20 lines, frame pulse on
// line 12, vsync on lines 14..15) and CLK_HZ=20 so the slow clock toggles
// every 10 cycles.
module tb_vga_timing_core;

  logic       clock_50M = 1'b0;
  logic       reset     = 1'b1;
  logic       clock_25M;
  logic       pix_tick;
  logic       clock_1Hz;
  logic [9:0] sx;
  logic [9:0] sy;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic       frame;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  vga_timing_core #(
    .CLK_HZ  (20),
    .SLOW_HZ (1),
    .V_ACTIVE(12),
    .V_FP    (2),
    .V_SYNC  (2),
    .V_BP    (4)
  ) dut (
    .clock_50M(clock_50M),
    .reset    (reset),
    .clock_25M(clock_25M),
    .pix_tick (pix_tick),
    .clock_1Hz(clock_1Hz),
    .sx       (sx),
    .sy       (sy),
    .hsync    (hsync),
    .vsync    (vsync),
    .de       (de),
    .frame    (frame)
  );

  always #5 clock_50M = ~clock_50M;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int unsigned guard;
    int unsigned cyc, f1, f2, nframes, fwidth;
    int unsigned de_hi, hs_lo, vs_lo;
    int unsigned hs_min, hs_max, de_max, de_lo_min, vs_min, vs_max;
    logic        prev_frame, wrapped, prev_slow;
    logic [9:0]  psx, psy;
    int unsigned nt, t1, t2;

    // Test 1: reset held for 3 edges, then release
    repeat (3) @(posedge clock_50M);
    @(negedge clock_50M);
    check("rst_clock_25M", 32'(clock_25M), 0);
    check("rst_pix_tick",  32'(pix_tick),  1);
    check("rst_clock_1Hz", 32'(clock_1Hz), 0);
    check("rst_sx",        32'(sx),        0);
    check("rst_sy",        32'(sy),        0);
    check("rst_hsync",     32'(hsync),     1);
    check("rst_vsync",     32'(vsync),     1);
    check("rst_de",        32'(de),        1);
    check("rst_frame",     32'(frame),     0);
    reset = 1'b0;
    // First edge sees pix_tick=1, so sx steps 1,1,2,2 while clock_25M goes 1,0,1,0
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock_50M);
      check("start_clock_25M", 32'(clock_25M), 32'(i % 2));
      check("start_sx",        32'(sx),        32'((i + 1) / 2));
    end

    // Test 2: end of line 0 wraps to start of line 1
    guard = 0;
    while (!(sx == 10'd799 && sy == 10'd0) && guard < 3000) begin
      @(negedge clock_50M);
      guard++;
    end
    check("reach_799_0", 32'(guard < 3000), 1);
    guard = 0;
    while (sx == 10'd799 && guard < 4) begin
      @(negedge clock_50M);
      guard++;
    end
    check("line_wrap_hold", guard, 2);
    check("line_wrap_sx", 32'(sx), 0);
    check("line_wrap_sy", 32'(sy), 1);

    // Tests 3/4: run to the second frame pulse, watching vsync, frame wrap and line 0 of frame 2
    cyc = 0; f1 = 0; f2 = 0; nframes = 0; fwidth = 0;
    de_hi = 0; hs_lo = 0; vs_lo = 0;
    hs_min = 1023; hs_max = 0; de_max = 0; de_lo_min = 1023; vs_min = 1023; vs_max = 0;
    prev_frame = frame; wrapped = 1'b0; psx = sx; psy = sy;
    while (nframes < 2 && cyc < 80000) begin
      @(negedge clock_50M);
      cyc++;
      if (frame) begin
        fwidth++;
        if (!prev_frame) begin
          nframes++;
          if (nframes == 1) f1 = cyc;
          else              f2 = cyc;
          check("frame_sx", 32'(sx), 0);
          check("frame_sy", 32'(sy), 12);
        end
      end else if (prev_frame) begin
        check("frame_width", fwidth, 2);
        fwidth = 0;
      end
      if (!wrapped && psx == 10'd799 && psy == 10'd19 && sx != psx) begin
        wrapped = 1'b1;
        check("frame_wrap_sx", 32'(sx), 0);
        check("frame_wrap_sy", 32'(sy), 0);
      end
      if (!wrapped && !vsync) begin
        vs_lo++;
        if (32'(sy) < vs_min) vs_min = 32'(sy);
        if (32'(sy) > vs_max) vs_max = 32'(sy);
      end
      if (wrapped && sy == 10'd0) begin
        if (de) begin
          de_hi++;
          if (32'(sx) > de_max) de_max = 32'(sx);
        end else if (32'(sx) < de_lo_min) begin
          de_lo_min = 32'(sx);
        end
        if (!hsync) begin
          hs_lo++;
          if (32'(sx) < hs_min) hs_min = 32'(sx);
          if (32'(sx) > hs_max) hs_max = 32'(sx);
        end
      end
      psx = sx; psy = sy; prev_frame = frame;
    end
    check("frame_wrapped",   32'(wrapped), 1);
    check("frame_count",     nframes, 2);
    check("frame_period",    f2 - f1, 32000);
    check("vsync_low_cyc",   vs_lo,  3200);
    check("vsync_first_sy",  vs_min, 14);
    check("vsync_last_sy",   vs_max, 15);
    check("de_high_cyc",     de_hi,  1280);
    check("de_last_sx",      de_max, 639);
    check("de_first_off_sx", de_lo_min, 640);
    check("hsync_low_cyc",   hs_lo,  192);
    check("hsync_first_sx",  hs_min, 656);
    check("hsync_last_sx",   hs_max, 751);

    // Test 5: slow clock with a half-period of 10 cycles
    reset = 1'b1;
    @(negedge clock_50M);
    check("slow_rst", 32'(clock_1Hz), 0);
    reset = 1'b0;
    prev_slow = clock_1Hz; nt = 0; t1 = 0; t2 = 0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clock_50M);
      if (clock_1Hz != prev_slow) begin
        nt++;
        if (nt == 1) t1 = 32'(e);
        if (nt == 2) t2 = 32'(e);
      end
      if (e == 5)  check("slow_low_phase",  32'(clock_1Hz), 0);
      if (e == 15) check("slow_high_phase", 32'(clock_1Hz), 1);
      prev_slow = clock_1Hz;
    end
    check("slow_toggles",     nt, 4);
    check("slow_first_edge",  t1, 10);
    check("slow_second_edge", t2, 20);

    // Test 6: reset mid-line, mid-frame with clock_1Hz high
    guard = 0;
    while (!(sy == 10'd5 && sx >= 10'd300 && clock_1Hz) && guard < 20000) begin
      @(negedge clock_50M);
      guard++;
    end
    check("midrst_reached", 32'(guard < 20000), 1);
    reset = 1'b1;
    @(negedge clock_50M);
    check("midrst_sx",        32'(sx),        0);
    check("midrst_sy",        32'(sy),        0);
    check("midrst_clock_25M", 32'(clock_25M), 0);
    check("midrst_clock_1Hz", 32'(clock_1Hz), 0);
    check("midrst_hsync",     32'(hsync),     1);
    check("midrst_vsync",     32'(vsync),     1);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
